// File: rtl/ifetch_unit.sv
// ifetch_unit: RV32 fetch stage -- owns the PC, reads instruction memory, buffers words for decode.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        resetn,
  output logic [31:0] MEM_addr,
  output logic        rMEM_en,
  input  logic [31:0] MEM_dout,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_fault,
  output logic        halted
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
  state_t        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          fault_q, fault_d;
  logic [31:0]   data_q [FIFO_DEPTH];
  logic [31:0]   data_d [FIFO_DEPTH];
  logic [31:0]   ipc_q  [FIFO_DEPTH];
  logic [31:0]   ipc_d  [FIFO_DEPTH];
  logic          pop, fetch, is_ebreak;
  assign inst_valid  = cnt_q != '0;
  assign pop         = inst_valid && inst_ready;
  assign fetch       = state_q == RUN && !redirect_valid && (cnt_q < FULL || pop);
  assign is_ebreak   = MEM_dout == EBREAK;
  assign rMEM_en     = fetch;
  assign MEM_addr    = pc_q;
  assign inst_data   = data_q[rd_q];
  assign inst_pc     = ipc_q[rd_q];
  assign fetch_fault = fault_q;
  assign halted      = state_q == HALT;
  // Redirect wins over everything: flush, retarget, and suppress the fetch.
  always_comb begin
    data_d = data_q;
    ipc_d  = ipc_q;
    if (fetch) begin
      data_d[wr_q] = MEM_dout;
      ipc_d[wr_q]  = pc_q;
    end
    rd_d    = redirect_valid ? '0 : pop ? rd_q + AW'(1) : rd_q;
    wr_d    = redirect_valid ? '0 : fetch ? wr_q + AW'(1) : wr_q;
    cnt_d   = redirect_valid ? '0 : cnt_q + (AW+1)'(fetch) - (AW+1)'(pop);
    pc_d    = redirect_valid ? {redirect_pc[31:2], 2'b00} :
              (fetch && !is_ebreak) ? pc_q + 32'd4 : pc_q;
    fault_d = fault_q | (redirect_valid && redirect_pc[1:0] != 2'b00);
    state_d = redirect_valid ? RUN :
              state_q == BOOT ? RUN :
              (fetch && is_ebreak) ? HALT : state_q;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      fault_q <= 1'b0;
      data_q  <= '{default: '0};
      ipc_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
      data_q  <= data_d;
      ipc_q   <= ipc_d;
    end
  end
endmodule
